// File: rtl/cordic_vector_iter.sv
// Iterative CORDIC in vectoring mode: rotates (x, y) onto the positive x axis
// one micro-rotation per clock, returning the gain-scaled magnitude and the
// binary angle atan2(y, x) in [0, 360) deg.
module cordic_vector_iter #(
  parameter int N    = 31,
  parameter int M    = 31,
  parameter int ITER = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic signed [N:0]   in_x,
  input  logic signed [N:0]   in_y,
  output logic                out_valid,
  input  logic                out_ready,
  output logic signed [N+2:0] out_mag,
  output logic        [M:0]   out_angle
);

  localparam int W = N + 3;
  localparam logic [4:0] LAST = 5'(ITER - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PRE  = 2'd1;
  localparam logic [1:0] S_ITER = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]          state;
  logic signed [W-1:0] x, y;
  logic [M:0]          z;
  logic [4:0]          i;
  logic                zero_f;

  logic signed [W-1:0] x_sh, y_sh, x_nxt, y_nxt;
  logic [M:0]          z_nxt, atan_i;
  logic                d;

  // atan(2^-i) as a binary angle; 32-bit-scale table rounded to M+1 bits
  function automatic logic [M:0] atan_lut(input logic [3:0] idx);
    logic [31:0] t;
    logic [63:0] s;
    case (idx)
      4'd0:    t = 32'h20000000;
      4'd1:    t = 32'h12E4051E;
      4'd2:    t = 32'h09FB385B;
      4'd3:    t = 32'h051111D4;
      4'd4:    t = 32'h028B0D43;
      4'd5:    t = 32'h0145D7E1;
      4'd6:    t = 32'h00A2F61E;
      4'd7:    t = 32'h00517C55;
      4'd8:    t = 32'h0028BE53;
      4'd9:    t = 32'h00145F2F;
      4'd10:   t = 32'h000A2F98;
      4'd11:   t = 32'h000517CC;
      4'd12:   t = 32'h00028BE6;
      4'd13:   t = 32'h000145F3;
      4'd14:   t = 32'h0000A2FA;
      default: t = 32'h0000517D;
    endcase
    s = ({t, 32'h0} + (64'd1 << (62 - M))) >> (63 - M);
    return s[M:0];
  endfunction

  // One micro-rotation from the current x/y/z; d steers y towards zero
  always_comb begin
    x_sh   = x >>> i;
    y_sh   = y >>> i;
    atan_i = atan_lut(i[3:0]);
    d      = ~y[W-1];
    x_nxt  = x;
    y_nxt  = y;
    z_nxt  = z;
    if (d) begin
      x_nxt = x + y_sh;
      y_nxt = y - x_sh;
      z_nxt = z + atan_i;
    end else begin
      x_nxt = x - y_sh;
      y_nxt = y + x_sh;
      z_nxt = z - atan_i;
    end
  end

  // Control FSM and datapath registers; handshake flags are registered
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_mag   <= '0;
      out_angle <= '0;
      x         <= '0;
      y         <= '0;
      z         <= '0;
      i         <= '0;
      zero_f    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            x        <= {{2{in_x[N]}}, in_x};
            y        <= {{2{in_y[N]}}, in_y};
            zero_f   <= (in_x == '0) && (in_y == '0);
            in_ready <= 1'b0;
            state    <= S_PRE;
          end
        end
        S_PRE: begin
          // Fold the left half-plane onto the right; 180 deg goes into z
          if (x[W-1]) begin
            x <= -x;
            y <= -y;
            z <= {1'b1, {M{1'b0}}};
          end else begin
            z <= '0;
          end
          i     <= '0;
          state <= S_ITER;
        end
        S_ITER: begin
          x <= x_nxt;
          y <= y_nxt;
          z <= z_nxt;
          i <= i + 5'd1;
          if (i == LAST) begin
            out_mag   <= zero_f ? '0 : x_nxt;
            out_angle <= zero_f ? '0 : z_nxt;
            out_valid <= 1'b1;
            state     <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: begin
          state     <= S_IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_vector_iter.sv
// Bench for cordic_vector_iter: directed and random vectors compared against
// an integer model of the vectoring algorithm, plus handshake, latency,
// back-pressure and reset behaviour.
module tb_cordic_vector_iter;

  localparam int N    = 31;
  localparam int M    = 31;
  localparam int ITER = 16;
  localparam real PI  = 3.141592653589793;

  logic                clk = 1'b0;
  logic                rst;
  logic                in_valid;
  logic                in_ready;
  logic signed [N:0]   in_x;
  logic signed [N:0]   in_y;
  logic                out_valid;
  logic                out_ready;
  logic signed [N+2:0] out_mag;
  logic        [M:0]   out_angle;

  int     checks = 0;
  int     errors = 0;
  longint atab[16];
  real    kgain;

  always #5 clk = ~clk;

  cordic_vector_iter #(.N(N), .M(M), .ITER(ITER)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .in_y      (in_y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_mag   (out_mag),
    .out_angle (out_angle)
  );

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_tol(input string tag, input longint obs, input real ideal, input real tol);
    real diff;
    diff = real'(obs) - ideal;
    if (diff < 0.0) diff = -diff;
    checks++;
    assert (diff <= tol) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %f +/- %f", tag, obs, ideal, tol);
    end
  endtask

  // Vectoring CORDIC on plain 64-bit integers: fold into the right
  // half-plane, then drive y to zero with ITER shift-and-add steps.
  task automatic model(input logic signed [31:0] xi, input logic signed [31:0] yi,
                       output longint mag, output longint ang);
    longint x, y, z, xs, ys;
    x = longint'(xi);
    y = longint'(yi);
    z = 0;
    if (x < 0) begin
      x = -x;
      y = -y;
      z = 64'h80000000;
    end
    for (int k = 0; k < ITER; k++) begin
      xs = x >>> k;
      ys = y >>> k;
      if (y >= 0) begin
        x = x + ys;
        y = y - xs;
        z = (z + atab[k]) & 64'hFFFFFFFF;
      end else begin
        x = x - ys;
        y = y + xs;
        z = (z - atab[k]) & 64'hFFFFFFFF;
      end
    end
    if (xi == 0 && yi == 0) begin
      mag = 0;
      ang = 0;
    end else begin
      mag = x;
      ang = z;
    end
  endtask

  // Present one vector at the current falling edge, measure latency, check
  // the result, optionally stall for 'hold' cycles, then release.
  task automatic run_vec(input string tag, input logic signed [31:0] vx,
                         input logic signed [31:0] vy, input int hold);
    longint em, ea;
    int     n;
    real    r, ideal;
    model(vx, vy, em, ea);
    chk({tag, "_in_ready_idle"}, 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    in_x     = vx;
    in_y     = vy;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_x     = $urandom;
    in_y     = $urandom;
    chk({tag, "_in_ready_busy"}, 64'(in_ready), 64'd0);
    n = 0;
    do begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end while (out_valid !== 1'b1 && n < 40);
    chk({tag, "_latency"}, 64'(n), 64'(ITER + 1));
    chk({tag, "_mag"}, 64'(out_mag), em);
    chk({tag, "_angle"}, 64'(out_angle), ea);
    if (vx != 0 || vy != 0) begin
      r     = $sqrt(real'(vx) * real'(vx) + real'(vy) * real'(vy));
      ideal = kgain * r;
      chk_tol({tag, "_mag_ideal"}, longint'(out_mag), ideal, 16.0 + ideal * 1.0e-8);
    end
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1;
      in_x     = $urandom;
      in_y     = $urandom;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      chk({tag, "_hold_mag"}, 64'(out_mag), em);
      chk({tag, "_hold_angle"}, 64'(out_angle), ea);
      chk({tag, "_hold_valid"}, 64'(out_valid), 64'd1);
      chk({tag, "_hold_in_ready"}, 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_valid_fall"}, 64'(out_valid), 64'd0);
    chk({tag, "_in_ready_back"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    real p;
    bit  seen;

    p     = 1.0;
    kgain = 1.0;
    for (int k = 0; k < 16; k++) begin
      atab[k] = longint'($rtoi($atan(p) / (2.0 * PI) * 4294967296.0 + 0.5));
      if (k < ITER) kgain = kgain * $sqrt(1.0 + p * p);
      p = p / 2.0;
    end

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_x      = '0;
    in_y      = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_out_mag", 64'(out_mag), 64'd0);
    chk("reset_out_angle", 64'(out_angle), 64'd0);

    run_vec("pos_x", 32'sd1000, 32'sd0, 0);
    run_vec("pos_y", 32'sd0, 32'sd1000, 0);
    run_vec("neg_x", -32'sd1000, 32'sd0, 0);
    run_vec("quad4", 32'sd1000, -32'sd1000, 0);
    run_vec("most_neg", 32'sh80000000, 32'sd0, 0);
    run_vec("zero", 32'sd0, 32'sd0, 0);

    // Stall in DONE with stray in_valid pulses, then a back-to-back vector
    run_vec("stall", 32'sd123456, -32'sd987654, 10);
    run_vec("back2back", -32'sd50000, 32'sd70000, 0);

    // Reset while the iteration counter sits at 5
    in_valid = 1'b1;
    in_x     = 32'sd3000;
    in_y     = -32'sd7000;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_out_mag", 64'(out_mag), 64'd0);
    chk("midrst_out_angle", 64'(out_angle), 64'd0);
    seen = 1'b0;
    repeat (25) begin
      @(posedge clk);
      @(negedge clk);
      if (out_valid !== 1'b0) seen = 1'b1;
    end
    chk("midrst_no_result", 64'(seen), 64'd0);
    run_vec("after_rst", 32'sd3000, -32'sd7000, 0);

    for (int t = 0; t < 8; t++) begin
      run_vec("rand_full", $urandom, $urandom, 0);
    end
    for (int t = 0; t < 4; t++) begin
      run_vec("rand_small", 32'($urandom_range(0, 4000)) - 32'sd2000,
              32'($urandom_range(0, 4000)) - 32'sd2000, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
